// File: rtl/audio_mem_pkg.sv
// Shared widths and FSM state encoding for the SRAM sample playback path.
package audio_mem_pkg;

    localparam int unsigned ADDR_W   = 20;
    localparam int unsigned SAMPLE_W = 16;

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        WAIT,
        CAPTURE
    } reader_state_e;

endpackage

// File: rtl/sample_fifo.sv
// Power-of-two sample FIFO with synchronous flush; pop and push may coincide when full.
module sample_fifo
    import audio_mem_pkg::*;
#(
    parameter int unsigned Depth = 8
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    push_i,
    input  logic                    pop_i,
    input  logic                    flush_i,
    input  logic [SAMPLE_W-1:0]     data_i,
    output logic [SAMPLE_W-1:0]     data_o,
    output logic [$clog2(Depth):0]  count_o,
    output logic                    full_o,
    output logic                    empty_o
);

    localparam int unsigned PtrW = $clog2(Depth);

    logic [SAMPLE_W-1:0] mem_q [Depth];
    logic [PtrW-1:0]     wr_ptr_q, rd_ptr_q;
    logic [PtrW:0]       count_q;
    logic                do_push, do_pop;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == (PtrW + 1)'(Depth));
    assign do_pop  = pop_i && !empty_o;
    // Read of the head is combinational, so a push into the slot freed by a pop is safe.
    assign do_push = push_i && (!full_o || do_pop);
    assign data_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
            count_q <= count_q + (PtrW + 1)'(do_push) - (PtrW + 1)'(do_pop);
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push && !flush_i) mem_q[wr_ptr_q] <= data_i;
    end

endmodule

// File: rtl/sram_sample_reader.sv
// Streams sample words from an asynchronous SRAM into a FIFO and hands them out at audio rate.
module sram_sample_reader
    import audio_mem_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 8,
    parameter int unsigned READ_WAIT  = 2
) (
    input  logic                Clk,
    input  logic                Reset,
    input  logic                start,
    input  logic                stop,
    input  logic [ADDR_W-1:0]   base_addr,
    input  logic [ADDR_W-1:0]   length,
    input  logic                loop,
    input  logic                sample_req,
    output logic [SAMPLE_W-1:0] sample_out,
    output logic                sample_valid,
    output logic                busy,
    output logic                done,
    output logic                underflow,
    output logic [ADDR_W-1:0]   SRAM_ADDR,
    inout  wire  [SAMPLE_W-1:0] SRAM_DQ,
    output logic                SRAM_CE_N,
    output logic                SRAM_UB_N,
    output logic                SRAM_LB_N,
    output logic                SRAM_OE_N,
    output logic                SRAM_WE_N
);

    localparam int unsigned CntW  = $clog2(FIFO_DEPTH) + 1;
    localparam int unsigned WaitW = (READ_WAIT > 2) ? $clog2(READ_WAIT - 1) : 1;

    reader_state_e       state_q, state_d;
    logic [WaitW-1:0]    wait_q, wait_d;
    logic [ADDR_W-1:0]   fetch_addr_q, fetch_left_q, base_q, len_q;
    logic [ADDR_W-1:0]   addr_after, left_after;
    logic                loop_q, busy_q, done_q, underflow_q, valid_q;
    logic [SAMPLE_W-1:0] sample_q;

    logic                start_go, kill, push, pop, last_pop, room_after;
    logic [SAMPLE_W-1:0] fifo_head;
    logic [CntW-1:0]     fifo_count;
    logic                fifo_full, fifo_empty;

    assign start_go = start && !stop && (length != '0);
    assign kill     = stop || start_go;
    assign push     = (state_q == CAPTURE) && !kill;
    assign pop      = sample_req && busy_q && !fifo_empty && !kill;
    // Final word already captured and this pop drains the last entry.
    assign last_pop = pop && !loop_q && (fetch_left_q == '0) && (fifo_count == CntW'(1));

    sample_fifo #(
        .Depth(FIFO_DEPTH)
    ) u_fifo (
        .clk_i  (Clk),
        .rst_i  (Reset),
        .push_i (push),
        .pop_i  (pop),
        .flush_i(kill),
        .data_i (SRAM_DQ),
        .data_o (fifo_head),
        .count_o(fifo_count),
        .full_o (fifo_full),
        .empty_o(fifo_empty)
    );

    always_comb begin
        state_d    = state_q;
        wait_d     = wait_q;
        addr_after = fetch_addr_q + ADDR_W'(1);
        left_after = fetch_left_q - ADDR_W'(1);
        if (fetch_left_q == ADDR_W'(1) && loop_q) begin
            addr_after = base_q;
            left_after = len_q;
        end
        room_after = pop || (fifo_count != CntW'(FIFO_DEPTH - 1));
        unique case (state_q)
            IDLE: begin
                if (busy_q && (fetch_left_q != '0) && !fifo_full) state_d = SETUP;
            end
            SETUP: begin
                if (READ_WAIT == 1) begin
                    state_d = CAPTURE;
                end else begin
                    state_d = WAIT;
                    wait_d  = WaitW'(READ_WAIT - 2);
                end
            end
            WAIT: begin
                if (wait_q == '0) state_d = CAPTURE;
                else              wait_d  = wait_q - WaitW'(1);
            end
            CAPTURE: begin
                state_d = ((left_after != '0) && room_after) ? SETUP : IDLE;
            end
            default: state_d = IDLE;
        endcase
        if (kill) state_d = IDLE;
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q      <= IDLE;
            wait_q       <= '0;
            fetch_addr_q <= '0;
            fetch_left_q <= '0;
            base_q       <= '0;
            len_q        <= '0;
            loop_q       <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            underflow_q  <= 1'b0;
            valid_q      <= 1'b0;
            sample_q     <= '0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            done_q  <= last_pop;
            valid_q <= pop;

            if (stop) begin
                busy_q <= 1'b0;
            end else if (start_go) begin
                busy_q       <= 1'b1;
                base_q       <= base_addr;
                len_q        <= length;
                loop_q       <= loop;
                fetch_addr_q <= base_addr;
                fetch_left_q <= length;
            end else begin
                if (last_pop) busy_q <= 1'b0;
                if (push) begin
                    fetch_addr_q <= addr_after;
                    fetch_left_q <= left_after;
                end
            end

            if (start)                                            underflow_q <= 1'b0;
            else if (sample_req && busy_q && fifo_empty && !stop) underflow_q <= 1'b1;

            if (pop)                       sample_q <= fifo_head;
            else if (sample_req && !busy_q) sample_q <= '0;
        end
    end

    // Strobes decode straight from the async-reset state so Reset releases the SRAM at once.
    assign SRAM_CE_N    = (state_q == IDLE);
    assign SRAM_OE_N    = (state_q == IDLE);
    assign SRAM_UB_N    = (state_q == IDLE);
    assign SRAM_LB_N    = (state_q == IDLE);
    assign SRAM_WE_N    = 1'b1;
    assign SRAM_ADDR    = fetch_addr_q;
    assign sample_out   = sample_q;
    assign sample_valid = valid_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign underflow    = underflow_q;

endmodule
